// File: rtl/seg7_scan_display.sv
// seg7_scan_display: binary load -> sequential shift-add-3 BCD -> multiplexed N-digit 7-segment scan.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_display #(
   parameter int DIGITS     = 4,
   parameter int DATA_W     = 14,
   parameter int CLK_HZ     = 50000000,
   parameter int SCAN_HZ    = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic              FPGA_CLK,
   input  logic              RESET_BUT,
   input  logic [DATA_W-1:0] data,
   input  logic              load,
   input  logic [DIGITS-1:0] dot_pos,
   output logic              busy,
   output logic              overflow,
   output logic [6:0]        segment,
   output logic              dot,
   output logic [DIGITS-1:0] seg_enable
);
   localparam int P     = CLK_HZ / SCAN_HZ;
   localparam int PRE_W = $clog2(P);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   function automatic logic [63:0] max_display(input int n);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < n; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

   localparam logic [63:0] MAX_VAL = max_display(DIGITS);

   function automatic logic [6:0] seg7_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   // ---------------- binary to BCD converter ----------------
   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [BCD_W-1:0]  bcd_reg, bcd_next, bcd_adj;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              ovf_pending_reg, ovf_pending_next;
   logic [BCD_W-1:0]  disp_reg, disp_next;
   logic              overflow_reg, overflow_next;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                  : bcd_reg[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         state_reg       <= IDLE;
         shift_reg       <= '0;
         bcd_reg         <= '0;
         cnt_reg         <= '0;
         ovf_pending_reg <= 1'b0;
         disp_reg        <= '0;
         overflow_reg    <= 1'b0;
      end else begin
         state_reg       <= state_next;
         shift_reg       <= shift_next;
         bcd_reg         <= bcd_next;
         cnt_reg         <= cnt_next;
         ovf_pending_reg <= ovf_pending_next;
         disp_reg        <= disp_next;
         overflow_reg    <= overflow_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      shift_next       = shift_reg;
      bcd_next         = bcd_reg;
      cnt_next         = cnt_reg;
      ovf_pending_next = ovf_pending_reg;
      disp_next        = disp_reg;
      overflow_next    = overflow_reg;
      case (state_reg)
         IDLE: begin
            if (load) begin
               shift_next       = data;
               bcd_next         = '0;
               cnt_next         = '0;
               ovf_pending_next = (64'(data) > MAX_VAL);
               state_next       = SHIFT;
            end
         end
         SHIFT: begin
            bcd_next   = {bcd_adj[BCD_W-2:0], shift_reg[DATA_W-1]};
            shift_next = shift_reg << 1;
            cnt_next   = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(DATA_W - 1)) begin
               state_next = COMMIT;
            end
         end
         COMMIT: begin
            // display registers change only here, so no partial result is ever scanned
            disp_next     = bcd_reg;
            overflow_next = ovf_pending_reg;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy     = (state_reg != IDLE);
   assign overflow = overflow_reg;

   // ---------------- digit scanner ----------------
   logic [PRE_W-1:0] pre_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             slot_end;

   assign slot_end = (pre_reg == PRE_W'(P - 1));

   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         pre_reg <= '0;
         idx_reg <= '0;
      end else begin
         pre_reg <= slot_end ? '0 : pre_reg + PRE_W'(1);
         if (slot_end) begin
            idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
         end
      end
   end

   logic [3:0] nib [DIGITS];
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_nib
         assign nib[gi] = disp_reg[4*gi +: 4];
      end
   endgenerate

   logic blank_digit;
`ifdef SEG7_LZB_EN
   logic [DIGITS-1:0] lead_blank;
   logic              zero_run;

   // a digit is blanked when it and every digit above it are zero; digit 0 never blanks
   always_comb begin
      lead_blank = '0;
      zero_run   = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         zero_run      = zero_run && (nib[i] == 4'd0);
         lead_blank[i] = zero_run;
      end
   end

   assign blank_digit = lead_blank[idx_reg];
`else
   assign blank_digit = 1'b0;
`endif

   logic [6:0]        seg_pat;
   logic [DIGITS-1:0] en_pat;
   logic              dot_pat;

   always_comb begin
      seg_pat = 7'h00;
      en_pat  = '0;
      dot_pat = 1'b0;
      if (!slot_end) begin
         en_pat[idx_reg] = 1'b1;
         dot_pat         = dot_pos[idx_reg];
         if (overflow_reg) begin
            seg_pat = 7'b1000000;
         end else if (!blank_digit) begin
            seg_pat = seg7_decode(nib[idx_reg]);
         end
      end
   end

   logic [6:0]        segment_reg;
   logic              dot_reg;
   logic [DIGITS-1:0] seg_enable_reg;

   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         segment_reg    <= {7{ACTIVE_LOW}};
         dot_reg        <= ACTIVE_LOW;
         seg_enable_reg <= {DIGITS{ACTIVE_LOW}};
      end else begin
         segment_reg    <= seg_pat ^ {7{ACTIVE_LOW}};
         dot_reg        <= dot_pat ^ ACTIVE_LOW;
         seg_enable_reg <= en_pat ^ {DIGITS{ACTIVE_LOW}};
      end
   end

   assign segment    = segment_reg;
   assign dot        = dot_reg;
   assign seg_enable = seg_enable_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: DIGITS=4, DATA_W=14, P=10, active-low pins.
// Expectations follow SEG7_LZB_EN when the bench is built with that macro defined.
module tb_seg7_scan_display;
   localparam int DIGITS = 4;
   localparam int DATA_W = 14;
   localparam int P      = 10;
`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] data;
   logic              load;
   logic [DIGITS-1:0] dot_pos;
   logic              busy;
   logic              overflow;
   logic [6:0]        segment;
   logic              dot;
   logic [DIGITS-1:0] seg_enable;

   always #5 clk = ~clk;

   seg7_scan_display #(
      .DIGITS(DIGITS), .DATA_W(DATA_W), .CLK_HZ(1000), .SCAN_HZ(100), .ACTIVE_LOW(1'b1)
   ) dut (
      .FPGA_CLK(clk), .RESET_BUT(rst), .data(data), .load(load), .dot_pos(dot_pos),
      .busy(busy), .overflow(overflow), .segment(segment), .dot(dot), .seg_enable(seg_enable)
   );

   int checks_cnt = 0;
   int errors_cnt = 0;

   // active-low glyphs for '0'..'9', worked out by hand
   logic [6:0] seg_lut [0:9];
   logic [6:0] cap_seg [0:3];
   logic       cap_dot [0:3];
   int         cap_len [0:3];
   int         cap_blanks;
   int         cap_bad;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks_cnt++;
      if (act !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [DATA_W-1:0] v);
      data = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   // records one full scan period starting right after a blank slot
   task automatic capture();
      int  n = 0;
      bit  found;
      for (int d = 0; d < 4; d++) begin
         cap_len[d] = 0;
         cap_seg[d] = 7'h00;
         cap_dot[d] = 1'b0;
      end
      cap_blanks = 0;
      cap_bad    = 0;
      while (seg_enable !== 4'hF && n < 3 * DIGITS * P) begin
         tick();
         n++;
      end
      for (int c = 0; c < DIGITS * P; c++) begin
         tick();
         if (seg_enable === 4'hF) begin
            cap_blanks++;
            if (segment !== SEG_OFF || dot !== 1'b1) cap_bad++;
         end else begin
            found = 1'b0;
            for (int d = 0; d < 4; d++) begin
               if (seg_enable === ~(4'b0001 << d)) begin
                  found      = 1'b1;
                  cap_len[d] = cap_len[d] + 1;
                  cap_seg[d] = segment;
                  cap_dot[d] = dot;
               end
            end
            if (!found) cap_bad++;
         end
      end
   endtask

   task automatic check_display(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                                input logic [6:0] e1, input logic [6:0] e0);
      logic [6:0] exp_seg [0:3];
      exp_seg[0] = e0;
      exp_seg[1] = e1;
      exp_seg[2] = e2;
      exp_seg[3] = e3;
      capture();
      for (int d = 0; d < 4; d++) begin
         check($sformatf("%s_dig%0d", tag, d), 32'(cap_seg[d]), 32'(exp_seg[d]));
      end
      check($sformatf("%s_blanks", tag), 32'(cap_blanks), 32'd4);
      check($sformatf("%s_badcyc", tag), 32'(cap_bad), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      seg_lut[0] = 7'h40; seg_lut[1] = 7'h79; seg_lut[2] = 7'h24; seg_lut[3] = 7'h30;
      seg_lut[4] = 7'h19; seg_lut[5] = 7'h12; seg_lut[6] = 7'h02; seg_lut[7] = 7'h78;
      seg_lut[8] = 7'h00; seg_lut[9] = 7'h10;

      rst = 1'b1; data = '0; load = 1'b0; dot_pos = '0;
      tick();
      tick();
      check("rst_busy",    32'(busy),       32'd0);
      check("rst_ovf",     32'(overflow),   32'd0);
      check("rst_segment", 32'(segment),    32'h7F);
      check("rst_dot",     32'(dot),        32'd1);
      check("rst_enable",  32'(seg_enable), 32'hF);
      rst = 1'b0;
      tick();
      check("first_enable",  32'(seg_enable), 32'hE);
      check("first_segment", 32'(segment),    32'(seg_lut[0]));

      // 1234: busy length, digit order, slot lengths
      do_load(14'd1234);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
      check("busy_len", 32'(n), 32'd15);
      check_display("v1234", seg_lut[1], seg_lut[2], seg_lut[3], seg_lut[4]);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("slot_len%0d", d), 32'(cap_len[d]), 32'd9);
      end
      check("v1234_ovf", 32'(overflow), 32'd0);

      do_load(14'd7);
      wait_idle("v7_idle");
      if (LZB) check_display("v7", SEG_OFF, SEG_OFF, SEG_OFF, seg_lut[7]);
      else     check_display("v7", seg_lut[0], seg_lut[0], seg_lut[0], seg_lut[7]);

      do_load(14'd10000);
      wait_idle("v10000_idle");
      check("v10000_ovf", 32'(overflow), 32'd1);
      check_display("v10000", SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH);

      do_load(14'd9999);
      wait_idle("v9999_idle");
      check("v9999_ovf", 32'(overflow), 32'd0);
      check_display("v9999", seg_lut[9], seg_lut[9], seg_lut[9], seg_lut[9]);

      // second load three cycles into a conversion is dropped
      do_load(14'd5678);
      tick();
      tick();
      do_load(14'd1111);
      check("busy_mid", 32'(busy), 32'd1);
      wait_idle("v5678_idle");
      check_display("v5678", seg_lut[5], seg_lut[6], seg_lut[7], seg_lut[8]);

      // load on the commit edge is dropped, the following cycle is accepted
      do_load(14'd3000);
      repeat (14) tick();
      data = 14'd2222;
      load = 1'b1;
      tick();
      check("commit_edge_load", 32'(busy), 32'd0);
      data = 14'd8888;
      tick();
      load = 1'b0;
      check("next_cycle_load", 32'(busy), 32'd1);
      wait_idle("v8888_idle");
      check_display("v8888", seg_lut[8], seg_lut[8], seg_lut[8], seg_lut[8]);

      dot_pos = 4'b0100;
      capture();
      check("dot_d0", 32'(cap_dot[0]), 32'd1);
      check("dot_d1", 32'(cap_dot[1]), 32'd1);
      check("dot_d2", 32'(cap_dot[2]), 32'd0);
      check("dot_d3", 32'(cap_dot[3]), 32'd1);
      check("dot_blank", 32'(cap_bad), 32'd0);
      dot_pos = 4'b0000;

      // asynchronous reset in the middle of converting 4321
      do_load(14'd4321);
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      check("arst_busy",    32'(busy),       32'd0);
      check("arst_enable",  32'(seg_enable), 32'hF);
      check("arst_segment", 32'(segment),    32'h7F);
      check("arst_dot",     32'(dot),        32'd1);
      check("arst_ovf",     32'(overflow),   32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      if (LZB) check_display("post_rst", SEG_OFF, SEG_OFF, SEG_OFF, seg_lut[0]);
      else     check_display("post_rst", seg_lut[0], seg_lut[0], seg_lut[0], seg_lut[0]);
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end
endmodule
